// File: rtl/sub_serial_cin.sv
// Digit-serial subtractor O = I0 - I1 - BIN, DIGIT bits per clock, LSD first, ready/valid on both sides.
// Define SUB_SERIAL_CIN_OVF_EN to add the registered signed-overflow output OVF.
module sub_serial_cin #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             BIN,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] O,
  output logic             BOUT,
  output logic             O_VALID,
  input  logic             O_READY
`ifdef SUB_SERIAL_CIN_OVF_EN
  , output logic           OVF
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  localparam logic [KW-1:0] K_ZERO = KW'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One digit of a + ~b + ~borrow; the top bit is the carry (no-borrow) out.
  function automatic logic [DIGIT:0] sub_digit(input logic [DIGIT-1:0] a,
                                               input logic [DIGIT-1:0] b,
                                               input logic             borrow);
    sub_digit = {1'b0, a} + {1'b0, ~b} + {{DIGIT{1'b0}}, ~borrow};
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_nxt_s;
  logic             borrow_r;
  logic [KW-1:0]    k_r;
  logic             i_ready_r;
  logic             accept_s;
  logic             last_s;
  logic [DIGIT-1:0] a_dig_s;
  logic [DIGIT-1:0] b_dig_s;
  logic [DIGIT-1:0] d_s;
  logic             c_s;
  logic             c_msb_in_s;

  assign I_READY = i_ready_r;

  // Current-digit arithmetic and the result with that digit merged in.
  always_comb begin
    a_dig_s     = a_r[int'(k_r)*DIGIT +: DIGIT];
    b_dig_s     = b_r[int'(k_r)*DIGIT +: DIGIT];
    {c_s, d_s}  = sub_digit(a_dig_s, b_dig_s, borrow_r);
    // Carry into the top bit recovered from its sum bit: s = a ^ ~b ^ cin.
    c_msb_in_s  = d_s[DIGIT-1] ^ a_dig_s[DIGIT-1] ^ ~b_dig_s[DIGIT-1];
    res_nxt_s   = res_r;
    res_nxt_s[int'(k_r)*DIGIT +: DIGIT] = d_s;
    accept_s    = (state_r == IDLE) && i_ready_r && I_VALID;
    last_s      = (state_r == RUN) && (k_r == K_LAST);
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_nxt_s = RUN;  else state_nxt_s = IDLE;
      RUN:     if (last_s)   state_nxt_s = DONE; else state_nxt_s = RUN;
      DONE:    if (O_READY)  state_nxt_s = IDLE; else state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Operand capture, digit datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_r       <= '0;
      b_r       <= '0;
      res_r     <= '0;
      borrow_r  <= 1'b0;
      k_r       <= K_ZERO;
      i_ready_r <= 1'b0;
      O         <= '0;
      BOUT      <= 1'b0;
      O_VALID   <= 1'b0;
`ifdef SUB_SERIAL_CIN_OVF_EN
      OVF       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r       <= I0;
            b_r       <= I1;
            borrow_r  <= BIN;
            k_r       <= K_ZERO;
            i_ready_r <= 1'b0;
          end else begin
            i_ready_r <= 1'b1;
          end
        end
        RUN: begin
          res_r    <= res_nxt_s;
          borrow_r <= ~c_s;
          k_r      <= k_r + K_ONE;
          if (last_s) begin
            O       <= res_nxt_s;
            BOUT    <= ~c_s;
            O_VALID <= 1'b1;
`ifdef SUB_SERIAL_CIN_OVF_EN
            OVF     <= c_s ^ c_msb_in_s;
`endif
          end
        end
        DONE: begin
          if (O_READY) begin
            O_VALID   <= 1'b0;
            i_ready_r <= 1'b1;
          end
        end
        default: begin
          O_VALID   <= 1'b0;
          i_ready_r <= 1'b0;
        end
      endcase
    end
  end

`ifndef SUB_SERIAL_CIN_OVF_EN
  logic unused_s;
  assign unused_s = c_msb_in_s;
`endif

endmodule

// File: tb/tb_sub_serial_cin.sv
// Self-checking bench for sub_serial_cin (WIDTH=8, DIGIT=2): vector table, corner sequences, random ops vs arithmetic model.
module tb_sub_serial_cin;

  logic       CLK;
  logic       RESET;
  logic [7:0] I0;
  logic [7:0] I1;
  logic       BIN;
  logic       I_VALID;
  logic       I_READY;
  logic [7:0] O;
  logic       BOUT;
  logic       O_VALID;
  logic       O_READY;
  logic       OVF;

  int tests_run = 0;
  int tests_failed = 0;

  sub_serial_cin #(.WIDTH(8), .DIGIT(2)) dut (
    .CLK(CLK), .RESET(RESET), .I0(I0), .I1(I1), .BIN(BIN),
    .I_VALID(I_VALID), .I_READY(I_READY), .O(O), .BOUT(BOUT),
    .O_VALID(O_VALID), .O_READY(O_READY)
`ifdef SUB_SERIAL_CIN_OVF_EN
    , .OVF(OVF)
`endif
  );

`ifndef SUB_SERIAL_CIN_OVF_EN
  assign OVF = 1'b0;
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] i0;
    logic [7:0] i1;
    logic       bin;
    logic [7:0] o;
    logic       bout;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed interpretations.
  task automatic ref_sub(input logic [7:0] x, input logic [7:0] y, input logic b,
                         output logic [7:0] o, output logic bo, output logic ov);
    int u;
    int s;
    u  = int'(x) - int'(y) - int'(b);
    s  = int'($signed(x)) - int'($signed(y)) - int'(b);
    o  = 8'(u);
    bo = (u < 0);
    ov = (s < -128) || (s > 127);
  endtask

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic b,
                       input logic [7:0] eo, input logic eb, input logic ev);
    int n;
    n = 0;
    O_READY = 1'b1;
    while (!I_READY && n < 20) begin @(negedge CLK); n++; end
    chk("i_ready_before_accept", 32'(I_READY), 32'd1);
    I0 = x; I1 = y; BIN = b; I_VALID = 1'b1;
    @(negedge CLK);
    I_VALID = 1'b0; I0 = 8'($urandom); I1 = 8'($urandom); BIN = 1'($urandom);
    n = 0;
    while (!O_VALID && n < 20) begin @(negedge CLK); n++; end
    chk("latency", 32'(n), 32'd4);
    chk("o", 32'(O), 32'(eo));
    chk("bout", 32'(BOUT), 32'(eb));
`ifdef SUB_SERIAL_CIN_OVF_EN
    chk("ovf", 32'(OVF), 32'(ev));
`endif
    @(negedge CLK);
    chk("o_valid_one_cycle", 32'(O_VALID), 32'd0);
  endtask

  initial begin
    logic [7:0] ro;
    logic       rb;
    logic       rv;
    logic [7:0] rx;
    logic [7:0] ry;
    logic       rbin;
    int         n;

    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[9] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};

    RESET = 1'b1; I0 = 8'h00; I1 = 8'h00; BIN = 1'b0; I_VALID = 1'b0; O_READY = 1'b0;
    @(negedge CLK); @(negedge CLK);
    chk("reset_o_valid", 32'(O_VALID), 32'd0);
    chk("reset_o", 32'(O), 32'd0);
    chk("reset_bout", 32'(BOUT), 32'd0);
    chk("reset_i_ready", 32'(I_READY), 32'd0);
`ifdef SUB_SERIAL_CIN_OVF_EN
    chk("reset_ovf", 32'(OVF), 32'd0);
`endif
    RESET = 1'b0;
    @(negedge CLK);
    chk("i_ready_after_reset", 32'(I_READY), 32'd1);

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].i0, vecs[i].i1, vecs[i].bin, vecs[i].o, vecs[i].bout, vecs[i].ovf);

    // Hold in DONE with O_READY low while new operands are offered.
    O_READY = 1'b0;
    I0 = 8'h35; I1 = 8'h12; BIN = 1'b0; I_VALID = 1'b1;
    @(negedge CLK);
    I0 = 8'hC3; I1 = 8'h5A; BIN = 1'b1;
    n = 0;
    while (!O_VALID && n < 20) begin @(negedge CLK); n++; end
    chk("hold_latency", 32'(n), 32'd4);
    for (int c = 0; c < 5; c++) begin
      I0 = 8'($urandom); I1 = 8'($urandom);
      @(negedge CLK);
      chk("hold_o", 32'(O), 32'h23);
      chk("hold_bout", 32'(BOUT), 32'd0);
      chk("hold_o_valid", 32'(O_VALID), 32'd1);
      chk("hold_i_ready", 32'(I_READY), 32'd0);
    end
    I_VALID = 1'b0; O_READY = 1'b1;
    @(negedge CLK);
    chk("release_o_valid", 32'(O_VALID), 32'd0);
    chk("release_i_ready", 32'(I_READY), 32'd1);
    chk("release_o_kept", 32'(O), 32'h23);

    // Reset on the second RUN cycle abandons the operation.
    I0 = 8'h00; I1 = 8'h01; BIN = 1'b0; I_VALID = 1'b1;
    @(negedge CLK);
    I_VALID = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk("midrun_reset_o_valid", 32'(O_VALID), 32'd0);
    chk("midrun_reset_o", 32'(O), 32'd0);
    chk("midrun_reset_bout", 32'(BOUT), 32'd0);
    chk("midrun_reset_i_ready", 32'(I_READY), 32'd0);
    RESET = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      chk("abandoned_no_output", 32'(O_VALID), 32'd0);
    end
    chk("i_ready_after_midrun_reset", 32'(I_READY), 32'd1);
    do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

    // Random operations against the arithmetic model.
    for (int r = 0; r < 40; r++) begin
      rx = 8'($urandom); ry = 8'($urandom); rbin = 1'($urandom);
      if (r == 0) begin rx = 8'h00; ry = 8'hFF; rbin = 1'b1; end
      if (r == 1) begin rx = 8'hFF; ry = 8'hFF; rbin = 1'b0; end
      ref_sub(rx, ry, rbin, ro, rb, rv);
      do_op(rx, ry, rbin, ro, rb, rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
